pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline hazard controller -- RAW stall in ID, multi-cycle MEM hold, taken-branch flush of ID/EX.
// Latency: all outputs combinational from tracked stage state plus current-cycle inputs; state updates each clk edge.
// Backpressure: o_stall holds ID on a RAW hazard; a MEM wait holds stages 0..MEM and bubbles WB.
module pipe_hazard_ctrl #(
   parameter int NSTAGES = 4,
   parameter int REG_AW  = 4,
   parameter int MEMW    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_dec_valid,
   input  logic [REG_AW-1:0]   i_dec_rs_a,
   input  logic [REG_AW-1:0]   i_dec_rs_b,
   input  logic [1:0]          i_dec_rs_en,
   input  logic [REG_AW-1:0]   i_dec_rd,
   input  logic                i_dec_rd_en,
   input  logic [MEMW-1:0]     i_dec_mem_cycles,
   input  logic                i_branch_taken,
   output logic [NSTAGES-1:0]  o_stall,
   output logic [NSTAGES-1:0]  o_flush,
   output logic                o_busy
);

   localparam int MEM_S = NSTAGES - 2;   // memory stage
   localparam int WB_S  = NSTAGES - 1;   // write-back stage
   localparam int PRE_S = NSTAGES - 3;   // stage feeding MEM (EX when NSTAGES=4)

   typedef struct packed {
      logic              vld;
      logic [REG_AW-1:0] rd;
      logic              rd_en;
      logic [MEMW-1:0]   mc;
   } ent_t;

   ent_t              r_ent [1:NSTAGES-1];
   logic [MEMW-1:0]   r_cnt;

   logic              w_mem_wait;
   logic              w_raw;
   logic              w_br;
   logic              w_any_vld;
   logic [NSTAGES-1:0] w_stall;
   logic [NSTAGES-1:0] w_flush;

   // Hazard detection and stall/flush priority: MEM wait > branch flush > RAW stall.
   // The branch only suppresses the ID stall; holds of stages 1+ never depend on it.
   always_comb begin
      w_mem_wait = (r_cnt != '0);
      w_raw      = 1'b0;
      w_any_vld  = 1'b0;
      for (int k = 1; k <= MEM_S; k++) begin
         if (r_ent[k].vld && r_ent[k].rd_en &&
             ((i_dec_rs_en[0] && (i_dec_rs_a == r_ent[k].rd)) ||
              (i_dec_rs_en[1] && (i_dec_rs_b == r_ent[k].rd))))
            w_raw = 1'b1;
      end
      for (int k = 1; k <= WB_S; k++) begin
         if (r_ent[k].vld)
            w_any_vld = 1'b1;
      end
      w_br    = !rst && i_branch_taken && r_ent[1].vld && !w_mem_wait;
      w_stall = '0;
      w_flush = '0;
      if (!rst) begin
         for (int k = 0; k <= MEM_S; k++)
            w_stall[k] = w_mem_wait;
         if (i_dec_valid && w_raw && !w_br)
            w_stall[0] = 1'b1;
         w_flush[1:0] = {2{w_br}};
      end
      o_stall = w_stall;
      o_flush = w_flush;
      o_busy  = !rst && (w_any_vld || w_mem_wait);
   end

   // Stage tracking shift and MEM wait counter; the counter is loaded as an entry enters MEM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= WB_S; k++)
            r_ent[k] <= '0;
         r_cnt <= '0;
      end else if (w_mem_wait) begin
         r_ent[WB_S] <= '0;
         r_cnt       <= r_cnt - MEMW'(1);
      end else begin
         r_ent[WB_S] <= r_ent[MEM_S];
         for (int k = 2; k <= MEM_S; k++)
            r_ent[k] <= r_ent[k-1];
         if (i_dec_valid && !w_stall[0] && !w_flush[0])
            r_ent[1] <= '{vld: 1'b1, rd: i_dec_rd, rd_en: i_dec_rd_en, mc: i_dec_mem_cycles};
         else
            r_ent[1] <= '0;
         if (r_ent[PRE_S].vld && (r_ent[PRE_S].mc > MEMW'(1)))
            r_cnt <= r_ent[PRE_S].mc - MEMW'(1);
         else
            r_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: directed self-checking bench for pipe_hazard_ctrl at NSTAGES=4.
// Latency: inputs driven on falling edge, outputs sampled 1 time unit later.
// Backpressure: not applicable; fixed-length directed sequences only.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic       i_dec_valid;
   logic [3:0] i_dec_rs_a;
   logic [3:0] i_dec_rs_b;
   logic [1:0] i_dec_rs_en;
   logic [3:0] i_dec_rd;
   logic       i_dec_rd_en;
   logic [3:0] i_dec_mem_cycles;
   logic       i_branch_taken;
   logic [3:0] o_stall;
   logic [3:0] o_flush;
   logic       o_busy;

   int checks;
   int failures;

   pipe_hazard_ctrl #(.NSTAGES(4), .REG_AW(4), .MEMW(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_dec_valid      (i_dec_valid),
      .i_dec_rs_a       (i_dec_rs_a),
      .i_dec_rs_b       (i_dec_rs_b),
      .i_dec_rs_en      (i_dec_rs_en),
      .i_dec_rd         (i_dec_rd),
      .i_dec_rd_en      (i_dec_rd_en),
      .i_dec_mem_cycles (i_dec_mem_cycles),
      .i_branch_taken   (i_branch_taken),
      .o_stall          (o_stall),
      .o_flush          (o_flush),
      .o_busy           (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one cycle: pass a rising edge and land on the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] en, input logic [3:0] rd, input logic rd_en,
                        input logic [3:0] mc);
      i_dec_valid      = v;
      i_dec_rs_a       = a;
      i_dec_rs_b       = b;
      i_dec_rs_en      = en;
      i_dec_rd         = rd;
      i_dec_rd_en      = rd_en;
      i_dec_mem_cycles = mc;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd0);
      i_branch_taken = 1'b0;
   endtask

   task automatic drain();
      idle();
      repeat (5) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 4'd1, 4'd2, 2'b11, 4'd1, 1'b1, 4'd3);
      i_branch_taken = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL rst_stall act=%b exp=%b", o_stall, 4'b0000); end
      checks++; if (o_flush !== 4'b0000) begin failures++; $display("FAIL rst_flush act=%b exp=%b", o_flush, 4'b0000); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy act=%b exp=%b", o_busy, 1'b0); end
      idle();
      tick();
      rst = 1'b0;
      #1;
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_release_busy act=%b exp=%b", o_busy, 1'b0); end
   endtask

   task automatic test_raw();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 4'd1);          // A writes r3
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL raw_a_issue act=%b exp=%b", o_stall, 4'b0000); end
      tick();
      drive(1'b1, 4'd3, 4'd0, 2'b01, 4'd5, 1'b1, 4'd1);          // B reads r3, writes r5
      #1;
      checks++; if (o_stall !== 4'b0001) begin failures++; $display("FAIL raw_a_ex act=%b exp=%b", o_stall, 4'b0001); end
      tick();
      #1;
      checks++; if (o_stall !== 4'b0001) begin failures++; $display("FAIL raw_a_mem act=%b exp=%b", o_stall, 4'b0001); end
      tick();
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL raw_a_wb act=%b exp=%b", o_stall, 4'b0000); end
      checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL raw_busy act=%b exp=%b", o_busy, 1'b1); end
      tick();
      drive(1'b1, 4'd0, 4'd5, 2'b10, 4'd0, 1'b0, 4'd1);          // C reads r5 via rs_b: B must now be in EX
      #1;
      checks++; if (o_stall !== 4'b0001) begin failures++; $display("FAIL raw_b_in_ex act=%b exp=%b", o_stall, 4'b0001); end
      drain();
      #1;
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL raw_drained_busy act=%b exp=%b", o_busy, 1'b0); end
   endtask

   task automatic test_mem_wait();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 4'd3);          // A: r7, 3 MEM cycles
      tick();
      idle();
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL mem_a_ex act=%b exp=%b", o_stall, 4'b0000); end
      tick();
      drive(1'b1, 4'd7, 4'd0, 2'b01, 4'd0, 1'b0, 4'd1);          // B reads r7, probes where A sits
      #1;
      checks++; if (o_stall !== 4'b0111) begin failures++; $display("FAIL mem_wait1 act=%b exp=%b", o_stall, 4'b0111); end
      tick();
      #1;
      checks++; if (o_stall !== 4'b0111) begin failures++; $display("FAIL mem_wait2 act=%b exp=%b", o_stall, 4'b0111); end
      tick();
      #1;
      checks++; if (o_stall !== 4'b0001) begin failures++; $display("FAIL mem_last_cycle act=%b exp=%b", o_stall, 4'b0001); end
      tick();
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL mem_a_in_wb act=%b exp=%b", o_stall, 4'b0000); end
      drain();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd2);          // X: 2 MEM cycles
      tick();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd2);          // Y: 2 MEM cycles
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL b2b_issue act=%b exp=%b", o_stall, 4'b0000); end
      tick();
      idle();
      #1;
      checks++; if (o_stall !== 4'b0111) begin failures++; $display("FAIL b2b_x_wait act=%b exp=%b", o_stall, 4'b0111); end
      tick();
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL b2b_x_release act=%b exp=%b", o_stall, 4'b0000); end
      tick();
      #1;
      checks++; if (o_stall !== 4'b0111) begin failures++; $display("FAIL b2b_y_wait act=%b exp=%b", o_stall, 4'b0111); end
      tick();
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL b2b_y_release act=%b exp=%b", o_stall, 4'b0000); end
      drain();
   endtask

   task automatic test_branch();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd1);          // branch instruction
      tick();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd9, 1'b1, 4'd1);          // D writes r9, must be discarded
      i_branch_taken = 1'b1;
      #1;
      checks++; if (o_flush !== 4'b0011) begin failures++; $display("FAIL br_flush act=%b exp=%b", o_flush, 4'b0011); end
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL br_stall act=%b exp=%b", o_stall, 4'b0000); end
      tick();
      i_branch_taken = 1'b1;                                     // EX is a bubble now: ignored
      drive(1'b1, 4'd9, 4'd0, 2'b01, 4'd0, 1'b0, 4'd1);          // E reads r9
      #1;
      checks++; if (o_flush !== 4'b0000) begin failures++; $display("FAIL br_one_cycle act=%b exp=%b", o_flush, 4'b0000); end
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL br_discarded act=%b exp=%b", o_stall, 4'b0000); end
      drain();
   endtask

   task automatic test_branch_raw();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 4'd1);          // A writes r4 (branch)
      tick();
      drive(1'b1, 4'd0, 4'd4, 2'b10, 4'd0, 1'b0, 4'd1);          // B reads r4
      i_branch_taken = 1'b1;
      #1;
      checks++; if (o_flush !== 4'b0011) begin failures++; $display("FAIL brraw_flush act=%b exp=%b", o_flush, 4'b0011); end
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL brraw_stall act=%b exp=%b", o_stall, 4'b0000); end
      i_branch_taken = 1'b0;
      #1;
      checks++; if (o_stall !== 4'b0001) begin failures++; $display("FAIL brraw_nobr_stall act=%b exp=%b", o_stall, 4'b0001); end
      drain();
   endtask

   task automatic test_branch_in_wait();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd3);          // A: 3 MEM cycles
      tick();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd1);          // B: branch that follows A
      tick();
      idle();
      i_branch_taken = 1'b1;
      #1;
      checks++; if (o_flush !== 4'b0000) begin failures++; $display("FAIL brwait_flush1 act=%b exp=%b", o_flush, 4'b0000); end
      checks++; if (o_stall !== 4'b0111) begin failures++; $display("FAIL brwait_stall1 act=%b exp=%b", o_stall, 4'b0111); end
      tick();
      #1;
      checks++; if (o_flush !== 4'b0000) begin failures++; $display("FAIL brwait_flush2 act=%b exp=%b", o_flush, 4'b0000); end
      tick();
      #1;
      checks++; if (o_flush !== 4'b0011) begin failures++; $display("FAIL brwait_reassert act=%b exp=%b", o_flush, 4'b0011); end
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL brwait_release act=%b exp=%b", o_stall, 4'b0000); end
      drain();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd6, 1'b1, 4'd3);          // A writes r6, 3 MEM cycles
      tick();
      idle();
      tick();
      #1;
      checks++; if (o_stall !== 4'b0111) begin failures++; $display("FAIL rstmid_wait act=%b exp=%b", o_stall, 4'b0111); end
      rst = 1'b1;
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL rstmid_during act=%b exp=%b", o_stall, 4'b0000); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_during act=%b exp=%b", o_busy, 1'b0); end
      tick();
      rst = 1'b0;
      drive(1'b1, 4'd6, 4'd6, 2'b11, 4'd0, 1'b0, 4'd1);          // reads r6
      #1;
      checks++; if (o_stall !== 4'b0000) begin failures++; $display("FAIL rstmid_stall act=%b exp=%b", o_stall, 4'b0000); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy act=%b exp=%b", o_busy, 1'b0); end
      checks++; if (o_flush !== 4'b0000) begin failures++; $display("FAIL rstmid_flush act=%b exp=%b", o_flush, 4'b0000); end
      drain();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle();
      test_reset();
      test_raw();
      test_mem_wait();
      test_back_to_back();
      test_branch();
      test_branch_raw();
      test_branch_in_wait();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
